part2: RTL and testbench

PART2 -- requirements
Module: part2

---
 rtl/part2.sv | 59 +++++
 tb/tb_part2.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/part2.sv
// Two-stage sum-of-squares accumulator: stage 1 registers the sample, stage 2
// squares it and adds it into a 20-bit saturating sum with a sticky overflow flag.
module part2 (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  a,
  input  logic        valid_in,
  output logic [19:0] f,
  output logic        valid_out,
  output logic        overflow
);

  localparam logic [20:0] SUM_MAX = 21'd1048575;

  logic [7:0]  a_r_q;
  logic        v_r_q;
  logic [19:0] f_q, f_d;
  logic        valid_out_q;
  logic        overflow_q, overflow_d;
  logic [15:0] sq;
  logic [20:0] sum;

  // One spare bit on the adder catches any carry out of the 20-bit sum.
  always_comb begin
    sq         = 16'(a_r_q) * 16'(a_r_q);
    sum        = {1'b0, f_q} + {5'b0, sq};
    f_d        = f_q;
    overflow_d = overflow_q;
    if (v_r_q) begin
      if (sum > SUM_MAX) begin
        f_d        = 20'hFFFFF;
        overflow_d = 1'b1;
      end else begin
        f_d = sum[19:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r_q       <= 8'd0;
      v_r_q       <= 1'b0;
      f_q         <= 20'd0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      a_r_q       <= a;
      v_r_q       <= valid_in;
      f_q         <= f_d;
      valid_out_q <= v_r_q;
      overflow_q  <= overflow_d;
    end
  end

  assign f         = f_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_part2.sv
// Bench for part2: hand-checked vector table, random stream against a
// saturating-sum reference model, overflow and asynchronous reset sequences.
module tb_part2;

  logic        clk;
  logic        reset;
  logic [7:0]  a;
  logic        valid_in;
  logic [19:0] f;
  logic        valid_out;
  logic        overflow;

  int tests;
  int fails;

  // Reference model: a sample entering at one edge shows up one edge later.
  longint m_sum;
  bit     m_ovf;
  bit     m_vo;
  int     m_pend_a;
  bit     m_pend_v;

  typedef struct {
    bit          rst;
    logic [7:0]  a;
    logic        v;
    logic [19:0] ef;
    logic        evo;
    logic        eovf;
  } vec_t;

  vec_t vecs[9];

  part2 dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .valid_in  (valid_in),
    .f         (f),
    .valid_out (valid_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic model_reset();
    m_sum    = 0;
    m_ovf    = 0;
    m_vo     = 0;
    m_pend_a = 0;
    m_pend_v = 0;
  endtask

  task automatic step(input logic [7:0] av, input logic vv);
    @(negedge clk);
    a        = av;
    valid_in = vv;
    @(posedge clk);
    #1;
    m_vo = m_pend_v;
    if (m_pend_v) begin
      m_sum += longint'(m_pend_a) * longint'(m_pend_a);
      if (m_sum > 1048575) begin
        m_sum = 1048575;
        m_ovf = 1;
      end
    end
    m_pend_a = int'(av);
    m_pend_v = vv;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".f"}, 32'(f), 32'(m_sum));
    check({tag, ".valid_out"}, 32'(valid_out), 32'(m_vo));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Assert reset between edges, hold it across two edges, release off-edge.
  task automatic do_reset(input int release_delay);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    a        = 8'd0;
    valid_in = 1'b0;
    #1;
    check("rst_async.f", 32'(f), 32'd0);
    check("rst_async.valid_out", 32'(valid_out), 32'd0);
    check("rst_async.overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held.f", 32'(f), 32'd0);
    check("rst_held.vo_ovf", 32'({valid_out, overflow}), 32'd0);
    #(release_delay);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    a        = 8'd0;
    valid_in = 1'b0;
    model_reset();

    //            rst  a  v  f   vo ovf
    vecs[0] = '{1'b1, 8'd3, 1'b1, 20'd0,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'd0, 1'b0, 20'd9,  1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'd0, 1'b0, 20'd9,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'd1, 1'b1, 20'd0,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'd2, 1'b1, 20'd1,  1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'd3, 1'b1, 20'd5,  1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'd4, 1'b1, 20'd14, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'd0, 1'b0, 20'd30, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'd0, 1'b0, 20'd30, 1'b0, 1'b0};

    #1;
    reset = 1'b0;
    #1;
    check("por.f", 32'(f), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset(1 + i % 3);
      step(vecs[i].a, vecs[i].v);
      check($sformatf("vec%0d.f", i), 32'(f), 32'(vecs[i].ef));
      check($sformatf("vec%0d.valid_out", i), 32'(valid_out), 32'(vecs[i].evo));
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].eovf));
    end

    // Random burst of valid samples, then an idle phase.
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      step(8'($urandom_range(0, 255)), 1'b1);
      check_model($sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      step(8'($urandom), 1'b0);
      check_model($sformatf("idle%0d", i));
    end

    // Random valid pattern with gaps.
    do_reset(3);
    for (int i = 0; i < 30; i++) begin
      step(8'($urandom), 1'($urandom_range(0, 1)));
      check_model($sformatf("gap%0d", i));
    end

    // Seventeen full-scale samples push the sum past 20 bits.
    do_reset(1);
    for (int i = 0; i < 17; i++) step(8'd255, 1'b1);
    check("ovf16.f", 32'(f), 32'd1040400);
    check("ovf16.overflow", 32'(overflow), 32'd0);
    begin
      int wide;
      wide = 300;
      step(8'(wide), 1'b1);
    end
    check("ovf17.f", 32'(f), 32'd1048575);
    check("ovf17.overflow", 32'(overflow), 32'd1);
    check("ovf17.valid_out", 32'(valid_out), 32'd1);
    step(8'd0, 1'b0);
    check("ovf_trunc.f", 32'(f), 32'd1048575);
    check("ovf_trunc.overflow", 32'(overflow), 32'd1);
    check("ovf_trunc.valid_out", 32'(valid_out), 32'd1);
    check_model("ovf_model");
    step(8'd0, 1'b0);
    check("ovf_idle.vo_ovf", 32'({valid_out, overflow}), 32'd1);
    check("ovf_idle.f", 32'(f), 32'd1048575);

    // Reset dropped between edges while a valid burst is running and overflow is set.
    step(8'd255, 1'b1);
    step(8'd255, 1'b1);
    check("mid_pre.vo_ovf", 32'({valid_out, overflow}), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst.f", 32'(f), 32'd0);
    check("mid_rst.valid_out", 32'(valid_out), 32'd0);
    check("mid_rst.overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_held.f", 32'(f), 32'd0);
    #7;
    reset = 1'b1;
    model_reset();
    valid_in = 1'b0;
    step(8'd5, 1'b1);
    check("post_rst.stage1", 32'(f), 32'd0);
    step(8'd0, 1'b0);
    check("post_rst.f", 32'(f), 32'd25);
    check("post_rst.valid_out", 32'(valid_out), 32'd1);
    check("post_rst.overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
